dcache_direct: RTL and testbench
================================

Name: dcache_direct

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the memory-stage load/store unit and the backing data RAM.
- Load hits return in the same cycle. Load misses and all stores raise stall_o; the pipeline holds every stage register and keeps the request stable until stall_o falls.
- Sign/zero extension of loaded data stays in the memory stage; this block returns raw words.

Parameters:
DATA_WIDTH, 32, data word width (bits)
ADDR_WIDTH, 32, byte address width
SETS, 64, number of cache lines (power of 2)
WORDS_PER_LINE, 4, words per line (power of 2); offset bits = log2(WORDS_PER_LINE*4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid_i  in  1  memory stage has a load/store this cycle
req_write_i  in  1  1=store, 0=load
addr_i  in  ADDR_WIDTH  byte address; word-aligned access, low 2 bits ignored for indexing
wdata_i  in  DATA_WIDTH  store data, already lane-aligned
byte_en_i  in  4  store byte strobes (bit n = byte lane n)
rdata_o  out  DATA_WIDTH  raw load word
stall_o  out  1  hold the pipeline
mem_req_valid_o  out  1  request to backing RAM
mem_req_ready_i  in  1  backing RAM accepts the request
mem_req_write_o  out  1  1=write, 0=line read
mem_addr_o  out  ADDR_WIDTH  request address (line-aligned for reads)
mem_wdata_o  out  DATA_WIDTH  write data
mem_byte_en_o  out  4  write strobes
mem_rvalid_i  in  1  refill beat valid
mem_rdata_i  in  DATA_WIDTH  refill beat data, in ascending word order

Behaviour:
- Clocking and reset: one clock (clk). Reset is rst, synchronous and active-high.
- On reset:
  - All valid bits clear.
  - FSM enters IDLE; refill beat counter = 0.
  - stall_o = 0, mem_req_valid_o = 0, rdata_o = 0.
  - Tag and data arrays need no reset.
- Address split: offset = addr_i[log2(WPL*4)-1:0]; word select = addr_i[log2(WPL*4)-1:2]; index = next log2(SETS) bits; tag = remaining upper bits. hit = valid[index] & (tag_array[index] == tag).
- FSM states: IDLE, WRITE, REFILL_REQ, REFILL_WAIT.
- IDLE, req_valid_i=0: stall_o = 0, no memory activity.
- IDLE, load hit:
  - rdata_o = word selected combinationally, stall_o = 0, zero latency.
  - rdata_o = 0 whenever the current cycle is not a load hit.
- IDLE, load miss: stall_o = 1 combinationally; next state is REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid_o = 1, mem_req_write_o = 0, mem_addr_o = addr_i with offset bits zeroed.
  - Request held stable until mem_req_ready_i; then go to REFILL_WAIT.
- REFILL_WAIT:
  - Each mem_rvalid_i writes mem_rdata_i into data[index][counter], then counter increments.
  - On the last beat (counter = WPL-1): write the tag, set valid, clear the counter, go to IDLE.
  - The held load then hits on the following cycle.
  - stall_o = 1 throughout REFILL_REQ and REFILL_WAIT.
  - Beats may arrive with gaps; mem_rvalid_i outside REFILL_WAIT is ignored.
- IDLE, store (hit or miss): stall_o = 1; next state is WRITE.
- WRITE:
  - mem_req_valid_o = 1, mem_req_write_o = 1, mem_addr_o = addr_i, mem_wdata_o = wdata_i, mem_byte_en_o = byte_en_i.
  - On the acceptance cycle (ready=1):
    - If hit, merge the enabled bytes into the cached word.
    - Return to IDLE with stall_o = 0 that same cycle, so the store retires.
  - A store miss does not allocate.
- Request outputs: when mem_req_valid_o = 0, mem_addr_o, mem_wdata_o and mem_byte_en_o are don't-care and mem_req_write_o = 0. No request is ever issued while one is outstanding.
- Reset mid-refill or mid-write:
  - Request dropped immediately, valid bits cleared, line not marked valid.
  - The backing RAM is reset by the same rst.
- A store to a line currently being refilled cannot occur, because the pipeline is stalled.

Test Plan:
- Reset, load 0x100, RAM ready after 1 cycle, beats A0..A3 = 0x11,0x22,0x33,0x44 → mem_addr_o = 0x100 with write = 0; stall_o high until the cycle after beat 4; rdata_o = 0x11. Then load 0x10C → same-cycle hit, rdata_o = 0x44, mem_req_valid_o stays 0.
- Line 0x100 cached (word 0x108 = 0x33), store 0xDEADBEEF to 0x108 with be = 1111, ready delayed 2 cycles → stall_o high 3 cycles; one write with addr 0x108; next load 0x108 hits → 0xDEADBEEF.
- Store-hit halfword: cached 0x104 = 0x11223344, store 0xABCD0000 with be = 1100 → RAM sees be = 1100; load 0x104 → 0xABCD3344.
- Store miss: store 0x55 to 0x2000 with be = 0001 → one RAM write, no refill; a following load to 0x2000 misses and issues a refill at 0x2000.
- Conflict (SETS = 64, 16 B lines): load 0x100, then 0x500 (same index) → second refill evicts the first; reloading 0x100 misses again.
- Assert rst after 2 refill beats → stall_o = 0 and mem_req_valid_o = 0 next cycle; load 0x100 misses and issues a fresh refill.

Source files
------------

// File: rtl/dcache_direct_if.sv
// Bus bundle between the memory-stage load/store unit, the data cache and the backing RAM.
// Signal suffixes are named from the cache's point of view.
interface dcache_direct_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Load/store unit side
    logic                  req_valid_i;
    logic                  req_write_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [3:0]            byte_en_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  stall_o;

    // Backing RAM side
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic                  mem_req_write_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [3:0]            mem_byte_en_o;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    // Cache view
    modport slave (
        input  req_valid_i, req_write_i, addr_i, wdata_i, byte_en_i,
        input  mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
        output rdata_o, stall_o,
        output mem_req_valid_o, mem_req_write_o, mem_addr_o, mem_wdata_o, mem_byte_en_o
    );

    // Pipeline + RAM view
    modport master (
        output req_valid_i, req_write_i, addr_i, wdata_i, byte_en_i,
        output mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
        input  rdata_o, stall_o,
        input  mem_req_valid_o, mem_req_write_o, mem_addr_o, mem_wdata_o, mem_byte_en_o
    );
endinterface

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Load hits return combinationally; load misses refill a whole line from the
// backing RAM in ascending word order; every store is forwarded to the RAM
// and merged into the cached word only when it hits.
module dcache_direct #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic            clk,
    input  logic            rst,
    dcache_direct_if.slave  bus
);
    localparam int OFF_W  = $clog2(WORDS_PER_LINE * 4);
    localparam int WSEL_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        REFILL_REQ,
        REFILL_WAIT
    } state_t;

    state_t                 state_q;
    logic [WSEL_W-1:0]      beat_q;
    logic [SETS-1:0]        valid_q;
    logic                   mem_req_valid_q;
    logic                   mem_req_write_q;
    logic [TAG_W-1:0]       tag_q  [SETS];
    logic [DATA_WIDTH-1:0]  data_q [SETS][WORDS_PER_LINE];

    logic [WSEL_W-1:0]      wsel;
    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   last_beat;
    logic                   stall_d;
    logic [DATA_WIDTH-1:0]  rdata_d;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [3:0]            be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

    // The request is held stable while stalled, so the lookup fields stay valid
    // through the whole refill or write.
    assign wsel      = bus.addr_i[OFF_W-1:2];
    assign idx       = bus.addr_i[OFF_W +: IDX_W];
    assign tag       = bus.addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign last_beat = (beat_q == WSEL_W'(WORDS_PER_LINE - 1));

    // Control FSM: state, beat counter, valid bits and registered request strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            beat_q          <= '0;
            valid_q         <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        if (bus.req_write_i) begin
                            state_q         <= WRITE;
                            mem_req_valid_q <= 1'b1;
                            mem_req_write_q <= 1'b1;
                        end else if (!hit) begin
                            state_q         <= REFILL_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_req_write_q <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_req_ready_i) begin
                        state_q         <= IDLE;
                        mem_req_valid_q <= 1'b0;
                        mem_req_write_q <= 1'b0;
                    end
                end
                REFILL_REQ: begin
                    if (bus.mem_req_ready_i) begin
                        state_q         <= REFILL_WAIT;
                        mem_req_valid_q <= 1'b0;
                        // The victim line is being overwritten from here on.
                        valid_q[idx]    <= 1'b0;
                    end
                end
                REFILL_WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        if (last_beat) begin
                            beat_q       <= '0;
                            valid_q[idx] <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    mem_req_valid_q <= 1'b0;
                    mem_req_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays: refill beats and store-hit byte merges; no reset needed.
    always_ff @(posedge clk) begin
        if (state_q == REFILL_WAIT && bus.mem_rvalid_i) begin
            data_q[idx][beat_q] <= bus.mem_rdata_i;
            if (last_beat) tag_q[idx] <= tag;
        end else if (state_q == WRITE && bus.mem_req_ready_i && hit) begin
            data_q[idx][wsel] <= merge_bytes(data_q[idx][wsel], bus.wdata_i, bus.byte_en_i);
        end
    end

    // Same-cycle hit data and stall; a store releases the pipeline on its acceptance cycle.
    always_comb begin
        stall_d = 1'b0;
        rdata_d = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        if (bus.req_write_i)  stall_d = 1'b1;
                        else if (hit)         rdata_d = data_q[idx][wsel];
                        else                  stall_d = 1'b1;
                    end
                end
                WRITE:   stall_d = !bus.mem_req_ready_i;
                default: stall_d = 1'b1;
            endcase
        end
    end

    assign bus.stall_o         = stall_d;
    assign bus.rdata_o         = rdata_d;
    assign bus.mem_req_valid_o = mem_req_valid_q && !rst;
    assign bus.mem_req_write_o = mem_req_write_q && !rst;
    assign bus.mem_addr_o      = (state_q == REFILL_REQ)
                               ? {bus.addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}}
                               : bus.addr_i;
    assign bus.mem_wdata_o     = bus.wdata_i;
    assign bus.mem_byte_en_o   = bus.byte_en_i;
endmodule

// File: tb/tb_dcache_direct.sv
// Directed bench for dcache_direct: stimulus pushes expected RAM requests and
// load results into queues; a monitor pops and compares them as the cache
// presents them. A small backing-RAM responder serves requests.
module tb_dcache_direct;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dcache_direct_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    dcache_direct #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(64), .WORDS_PER_LINE(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } mexp_t;

    mexp_t       mem_q[$];
    logic [31:0] load_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ready_delay = 1;
    logic        gap_mode = 1'b0;
    logic [31:0] ram [4096];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        mexp_t e;
        e.w = w; e.a = a; e.d = d; e.be = be;
        mem_q.push_back(e);
    endtask

    // Present one request and hold it until stall_o falls; returns stalled cycles.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int stalls);
        logic done;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = w;
        bus.addr_i      = a;
        bus.wdata_i     = d;
        bus.byte_en_i   = be;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.stall_o) stalls++;
            else done = 1'b1;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: request at 0x%08h still stalled after 200 cycles", a);
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
    endtask

    // Monitor: compares accepted RAM requests and retiring loads against the queues.
    initial begin
        mexp_t e;
        logic [31:0] l;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
                    if (mem_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_mem_req: got addr 0x%08h write %0b, expected none",
                                 bus.mem_addr_o, bus.mem_req_write_o);
                    end else begin
                        e = mem_q.pop_front();
                        chk("mem_write", {31'd0, bus.mem_req_write_o}, {31'd0, e.w});
                        chk("mem_addr", bus.mem_addr_o, e.a);
                        if (e.w) begin
                            chk("mem_wdata", bus.mem_wdata_o, e.d);
                            chk("mem_be", {28'd0, bus.mem_byte_en_o}, {28'd0, e.be});
                        end
                    end
                end
                if (bus.req_valid_i && !bus.req_write_i) begin
                    if (bus.stall_o) begin
                        chk("rdata_zero_while_stalled", bus.rdata_o, 32'h0);
                    end else if (load_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_load: got 0x%08h, expected none", bus.rdata_o);
                    end else begin
                        l = load_q.pop_front();
                        chk("load_rdata", bus.rdata_o, l);
                    end
                end
            end
        end
    end

    // Backing RAM responder: ready after ready_delay cycles, 4 ascending beats, optional gaps.
    initial begin
        int          wcnt, beat, ix;
        logic        pend, tog, acc, acc_w, taken;
        logic [31:0] acc_a, acc_d, line;
        logic [3:0]  acc_be;
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        ram[32'h100 >> 2] = 32'h11;
        ram[(32'h100 >> 2) + 1] = 32'h22;
        ram[(32'h100 >> 2) + 2] = 32'h33;
        ram[(32'h100 >> 2) + 3] = 32'h44;
        for (int i = 0; i < 4; i++) ram[(32'h500 >> 2) + i] = 32'h500 + i;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rvalid_i    = 1'b0;
        bus.mem_rdata_i     = 32'h0;
        wcnt = 0; beat = 0; pend = 1'b0; tog = 1'b0; line = 32'h0;
        forever begin
            @(negedge clk);
            acc    = bus.mem_req_valid_o && bus.mem_req_ready_i;
            acc_w  = bus.mem_req_write_o;
            acc_a  = bus.mem_addr_o;
            acc_d  = bus.mem_wdata_o;
            acc_be = bus.mem_byte_en_o;
            taken  = bus.mem_rvalid_i;
            @(posedge clk); #2;
            if (rst) begin
                pend = 1'b0; beat = 0; wcnt = 0;
                bus.mem_req_ready_i = 1'b0;
                bus.mem_rvalid_i    = 1'b0;
            end else begin
                if (taken) beat++;
                if (pend && beat >= 4) pend = 1'b0;
                if (acc) begin
                    if (acc_w) begin
                        ix = int'(acc_a >> 2) & 4095;
                        for (int b = 0; b < 4; b++)
                            if (acc_be[b]) ram[ix][b*8 +: 8] = acc_d[b*8 +: 8];
                    end else begin
                        pend = 1'b1; beat = 0; tog = 1'b0; line = acc_a;
                    end
                end
                if (bus.mem_req_valid_o) begin
                    if (wcnt >= ready_delay) bus.mem_req_ready_i = 1'b1;
                    else begin
                        bus.mem_req_ready_i = 1'b0;
                        wcnt++;
                    end
                end else begin
                    bus.mem_req_ready_i = 1'b0;
                    wcnt = 0;
                end
                bus.mem_rvalid_i = 1'b0;
                if (pend && beat < 4) begin
                    if (gap_mode && !tog) begin
                        tog = 1'b1;
                    end else begin
                        tog = 1'b0;
                        bus.mem_rvalid_i = 1'b1;
                        bus.mem_rdata_i  = ram[(int'(line >> 2) + beat) & 4095];
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int   st;
        int   beats;
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.addr_i      = 32'h0;
        bus.wdata_i     = 32'h0;
        bus.byte_en_i   = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("reset_mem_req_valid", {31'd0, bus.mem_req_valid_o}, 32'd0);
        chk("reset_rdata", bus.rdata_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Load miss at 0x100, RAM ready after 1 cycle: 1 IDLE + 2 REQ + 4 beats stalled.
        ready_delay = 1;
        exp_mem(1'b0, 32'h100, 32'h0, 4'h0);
        load_q.push_back(32'h11);
        issue(1'b0, 32'h100, 32'h0, 4'h0, st);
        chk("miss_stall_cycles", st, 7);
        load_q.push_back(32'h44);
        issue(1'b0, 32'h10C, 32'h0, 4'h0, st);
        chk("hit_stall_cycles", st, 0);

        // Store hit, ready delayed 2 cycles.
        ready_delay = 2;
        exp_mem(1'b1, 32'h108, 32'hDEADBEEF, 4'hF);
        issue(1'b1, 32'h108, 32'hDEADBEEF, 4'hF, st);
        chk("store_stall_cycles", st, 3);
        load_q.push_back(32'hDEADBEEF);
        issue(1'b0, 32'h108, 32'h0, 4'h0, st);
        chk("store_hit_reload_stall", st, 0);

        // Halfword store hit merges upper lanes only.
        ready_delay = 0;
        exp_mem(1'b1, 32'h104, 32'h11223344, 4'hF);
        issue(1'b1, 32'h104, 32'h11223344, 4'hF, st);
        exp_mem(1'b1, 32'h104, 32'hABCD0000, 4'hC);
        issue(1'b1, 32'h104, 32'hABCD0000, 4'hC, st);
        chk("store_ready0_stall", st, 1);
        load_q.push_back(32'hABCD3344);
        issue(1'b0, 32'h104, 32'h0, 4'h0, st);
        chk("merge_hit_stall", st, 0);

        // Store miss: one write, no allocate; the next load must refill.
        exp_mem(1'b1, 32'h2000, 32'h55, 4'h1);
        issue(1'b1, 32'h2000, 32'h55, 4'h1, st);
        exp_mem(1'b0, 32'h2000, 32'h0, 4'h0);
        load_q.push_back(32'h55);
        issue(1'b0, 32'h2000, 32'h0, 4'h0, st);
        chk("store_miss_no_alloc_stall", st, 6);

        // Conflict on index 0x10 with gapped refill beats.
        gap_mode = 1'b1;
        exp_mem(1'b0, 32'h500, 32'h0, 4'h0);
        load_q.push_back(32'h500);
        issue(1'b0, 32'h500, 32'h0, 4'h0, st);
        exp_mem(1'b0, 32'h100, 32'h0, 4'h0);
        load_q.push_back(32'h11);
        issue(1'b0, 32'h100, 32'h0, 4'h0, st);
        gap_mode = 1'b0;
        load_q.push_back(32'hABCD3344);
        issue(1'b0, 32'h104, 32'h0, 4'h0, st);
        chk("after_conflict_hit_stall", st, 0);

        // Reset after two refill beats of a load to 0x300.
        exp_mem(1'b0, 32'h300, 32'h0, 4'h0);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b0;
        bus.addr_i      = 32'h300;
        beats = 0;
        for (int i = 0; i < 200 && beats < 2; i++) begin
            @(negedge clk);
            if (bus.mem_rvalid_i) beats++;
        end
        chk("beats_before_reset", beats, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("post_reset_mem_req_valid", {31'd0, bus.mem_req_valid_o}, 32'd0);
        chk("post_reset_rdata", bus.rdata_o, 32'h0);
        exp_mem(1'b0, 32'h100, 32'h0, 4'h0);
        load_q.push_back(32'h11);
        issue(1'b0, 32'h100, 32'h0, 4'h0, st);
        chk("post_reset_refill_stall", st, 6);

        repeat (5) @(posedge clk);
        chk("mem_queue_drained", mem_q.size(), 0);
        chk("load_queue_drained", load_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
